and_five_bits: RTL and testbench
================================

AND_FIVE_BITS -- requirements
Module: and_five_bits

Interface
- REQ-001 SHALL have parameter WIDTH, default 5, operand/result width; legal range 1..32.
- REQ-002 SHALL have port clk  input  1  rising-edge clock for all registers.
- REQ-003 SHALL have port rst  input  1  reset; one clock, reset synchronous and active-high.
- REQ-004 SHALL have port in_valid  input  1  qualifies A/B for registered capture.
- REQ-005 SHALL have port A  input  WIDTH  first operand.
- REQ-006 SHALL have port B  input  WIDTH  second operand.
- REQ-007 SHALL have port out  output  WIDTH  combinational bitwise AND of A and B.
- REQ-008 SHALL have port out_q  output  WIDTH  registered AND result.
- REQ-009 SHALL have port out_valid  output  1  out_q and flags hold a fresh result this cycle.
- REQ-010 SHALL have port zero_q  output  1  registered result equals 0.
- REQ-011 SHALL have port ones_q  output  1  registered result is all ones.
- REQ-012 SHALL have port pop_q  output  clog2(WIDTH+1)  number of set bits in registered result.
- REQ-013 SHALL have port match_cnt  output  16  saturating count of accepted nonzero results; present only with AND_FIVE_BITS_STATS_EN.

Function
- REQ-014 out SHALL equal A & B bit-for-bit at all times, zero latency, independent of clk, rst and in_valid.
- REQ-015 On a rising clk with rst=0 and in_valid=1: out_q <= A & B; zero_q, ones_q, pop_q updated from that same value; out_valid <= 1.
- REQ-016 On a rising clk with rst=0 and in_valid=0: out_q, zero_q, ones_q, pop_q SHALL hold; out_valid <= 0.
- REQ-017 Registered latency SHALL be exactly one cycle; a new vector is accepted every cycle, no backpressure.
- REQ-018 zero_q, ones_q, pop_q SHALL always be consistent with current out_q (computed from the captured value, not from live A/B).
- REQ-019 ones_q and zero_q SHALL never both be 1 (WIDTH >= 1).
- REQ-020 X/Z-free inputs SHALL yield X-free outputs; no internal state other than listed registers.

Reset
- REQ-021 When rst=1 at a rising clk: out_q=0, out_valid=0, zero_q=1, ones_q=0, pop_q=0, match_cnt=0; rst dominates in_valid.
- REQ-022 out SHALL remain A & B during reset.
- REQ-023 The first cycle after rst deasserts SHALL accept a vector normally if in_valid=1.

Configuration
- REQ-024 Macro AND_FIVE_BITS_STATS_EN defined: match_cnt port and counter exist; counter increments by 1 on each accepted (in_valid=1, rst=0) vector whose A & B is nonzero, saturates at 16'hFFFF.
- REQ-025 Macro undefined: no match_cnt port and no counter logic; all other behaviour identical.

Structure
- REQ-026 A shared package and_five_bits_pkg SHALL hold the default width constant (5), the counter width constant (16) and a function returning clog2(WIDTH+1).
- REQ-027 Popcount SHALL be one sub-module, and_five_bits_popcount, parameterized by WIDTH, purely combinational.

Verification
- REQ-028 A=00000, B=00000, in_valid=1 -> out=00000; next cycle out_q=00000, zero_q=1, ones_q=0, pop_q=0, out_valid=1.
- REQ-029 A=11111, B=00111 -> out=00111; next cycle out_q=00111, pop_q=3, zero_q=0, ones_q=0.
- REQ-030 A=11000, B=11000 then A=10000, B=00000 back-to-back -> out_q 11000 (pop_q=2) then 00000 (zero_q=1) on consecutive cycles; with STATS_EN, match_cnt +1 only for the first.
- REQ-031 A=11111, B=11111, then in_valid=0 with A=00010, B=00010 -> ones_q=1, pop_q=5, out_valid=1, then out_valid=0 with out_q held at 11111 while out=00010.
- REQ-032 rst=1 asserted mid-stream with in_valid=1, A=B=11111 -> next cycle out_q=0, zero_q=1, out_valid=0, match_cnt=0, out=11111.
- REQ-033 STATS_EN: 65540 consecutive accepted nonzero vectors -> match_cnt=16'hFFFF, stays saturated.

Source files
------------

// File: rtl/and_five_bits_pkg.sv
// Shared constants and helpers for the and_five_bits block.
// The optional match statistics are enabled with AND_FIVE_BITS_STATS_EN.
package and_five_bits_pkg;

  localparam int DEFAULT_WIDTH = 5;
  localparam int CNT_WIDTH     = 16;

  // Width needed to hold a population count of 0..width inclusive.
  function automatic int popWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/and_five_bits_popcount.sv
// Purely combinational population count of a WIDTH-bit vector.
module and_five_bits_popcount
  import and_five_bits_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int POP_W = popWidth(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [POP_W-1:0] o_count
);

  logic [POP_W-1:0] w_count;

  always_comb begin
    w_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_count = w_count + POP_W'(i_vec[i]);
    end
  end

  assign o_count = w_count;

endmodule

// File: rtl/and_five_bits.sv
// Bitwise AND with a live result plus a registered result and its flags.
// Define AND_FIVE_BITS_STATS_EN to add the saturating match_cnt counter.
module and_five_bits
  import and_five_bits_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int POP_W = popWidth(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  output logic             zero_q,
  output logic             ones_q,
  output logic [POP_W-1:0] pop_q
`ifdef AND_FIVE_BITS_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] match_cnt
`endif
);

  logic [WIDTH-1:0] w_and;
  logic [POP_W-1:0] w_pop;
  logic             w_zero;
  logic             w_ones;

  logic [WIDTH-1:0] r_outQ;
  logic             r_outValid;
  logic             r_zero;
  logic             r_ones;
  logic [POP_W-1:0] r_pop;

  assign w_and  = A & B;
  assign w_zero = ~|w_and;
  assign w_ones = &w_and;

  and_five_bits_popcount #(.WIDTH(WIDTH)) u_popcount (
    .i_vec   (w_and),
    .o_count (w_pop)
  );

  // Flags are captured in the same edge as the result so they always describe out_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outQ     <= '0;
      r_outValid <= 1'b0;
      r_zero     <= 1'b1;
      r_ones     <= 1'b0;
      r_pop      <= '0;
    end else begin
      r_outValid <= in_valid;
      if (in_valid) begin
        r_outQ <= w_and;
        r_zero <= w_zero;
        r_ones <= w_ones;
        r_pop  <= w_pop;
      end
    end
  end

`ifdef AND_FIVE_BITS_STATS_EN
  logic [CNT_WIDTH-1:0] r_matchCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_matchCnt <= '0;
    end else if (in_valid && !w_zero && (r_matchCnt != {CNT_WIDTH{1'b1}})) begin
      r_matchCnt <= r_matchCnt + 1'b1;
    end
  end

  assign match_cnt = r_matchCnt;
`endif

  assign out       = w_and;
  assign out_q     = r_outQ;
  assign out_valid = r_outValid;
  assign zero_q    = r_zero;
  assign ones_q    = r_ones;
  assign pop_q     = r_pop;

endmodule

// File: tb/tb_and_five_bits.sv
// Scoreboard bench for and_five_bits: expected registered state is queued per
// driven cycle and compared one cycle later.
module tb_and_five_bits;

  localparam int W  = 5;
  localparam int PW = $clog2(W + 1);

  typedef struct packed {
    logic [W-1:0]  outQ;
    logic          valid;
    logic          zero;
    logic          ones;
    logic [PW-1:0] pop;
    logic [15:0]   cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic [W-1:0]  out;
  logic [W-1:0]  out_q;
  logic          out_valid;
  logic          zero_q;
  logic          ones_q;
  logic [PW-1:0] pop_q;
`ifdef AND_FIVE_BITS_STATS_EN
  logic [15:0]   match_cnt;
`endif

  int compared = 0;
  int mismatched = 0;

  exp_t sbq[$];
  exp_t model;
  exp_t exp;

  and_five_bits #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out       (out),
    .out_q     (out_q),
    .out_valid (out_valid),
    .zero_q    (zero_q),
    .ones_q    (ones_q),
    .pop_q     (pop_q)
`ifdef AND_FIVE_BITS_STATS_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic exp_t actual();
    exp_t a;
    a.outQ  = out_q;
    a.valid = out_valid;
    a.zero  = zero_q;
    a.ones  = ones_q;
    a.pop   = pop_q;
`ifdef AND_FIVE_BITS_STATS_EN
    a.cnt   = match_cnt;
`else
    a.cnt   = 16'h0;
`endif
    return a;
  endfunction

  // Drive one cycle at the falling edge, advance the model, return just after the rising edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] res;
    @(negedge clk);
    rst = r;
    in_valid = v;
    A = a;
    B = b;
    res = a & b;
    if (r) begin
      model.outQ = '0; model.valid = 1'b0; model.zero = 1'b1;
      model.ones = 1'b0; model.pop = '0; model.cnt = 16'h0;
    end else begin
      model.valid = v;
      if (v) begin
        model.outQ = res;
        model.zero = (res == '0);
        model.ones = (res == {W{1'b1}});
        model.pop  = PW'($countones(res));
`ifdef AND_FIVE_BITS_STATS_EN
        if (res != '0 && model.cnt != 16'hFFFF) model.cnt = model.cnt + 16'd1;
`endif
      end
    end
    sbq.push_back(model);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b1, 5'b11111, 5'b11111);
    applyStimulus(1'b1, 1'b1, 5'b11111, 5'b11111);
    repeat (2) begin
      exp = sbq.pop_front();
      compared++;
      if (actual() !== exp) begin
        mismatched++;
        $display("[TB] FAIL reset_state: got %h expected %h", actual(), exp);
      end
    end
    compared++;
    if (out !== 5'b11111) begin
      mismatched++;
      $display("[TB] FAIL reset_out_live: got %b expected 11111", out);
    end
  endtask

  task automatic test_zero();
    applyStimulus(1'b0, 1'b1, 5'b00000, 5'b00000);
    exp = sbq.pop_front();
    compared++;
    if (actual() !== exp || out_q !== 5'b00000 || zero_q !== 1'b1 || ones_q !== 1'b0
        || pop_q !== 3'd0 || out_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL zero_vector: got %h expected %h", actual(), exp);
    end
  endtask

  task automatic test_partial();
    applyStimulus(1'b0, 1'b1, 5'b11111, 5'b00111);
    compared++;
    if (out !== 5'b00111) begin
      mismatched++;
      $display("[TB] FAIL partial_out: got %b expected 00111", out);
    end
    exp = sbq.pop_front();
    compared++;
    if (actual() !== exp || out_q !== 5'b00111 || pop_q !== 3'd3 || zero_q !== 1'b0 || ones_q !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL partial_reg: got %h expected %h", actual(), exp);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b0, 1'b1, 5'b11000, 5'b11000);
    exp = sbq.pop_front();
    compared++;
    if (actual() !== exp || out_q !== 5'b11000 || pop_q !== 3'd2) begin
      mismatched++;
      $display("[TB] FAIL b2b_first: got %h expected %h", actual(), exp);
    end
    applyStimulus(1'b0, 1'b1, 5'b10000, 5'b00000);
    exp = sbq.pop_front();
    compared++;
    if (actual() !== exp || out_q !== 5'b00000 || zero_q !== 1'b1 || out_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL b2b_second: got %h expected %h", actual(), exp);
    end
  endtask

  task automatic test_hold();
    applyStimulus(1'b0, 1'b1, 5'b11111, 5'b11111);
    exp = sbq.pop_front();
    compared++;
    if (actual() !== exp || ones_q !== 1'b1 || pop_q !== 3'd5 || out_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL hold_capture: got %h expected %h", actual(), exp);
    end
    applyStimulus(1'b0, 1'b0, 5'b00010, 5'b00010);
    exp = sbq.pop_front();
    compared++;
    if (actual() !== exp || out_valid !== 1'b0 || out_q !== 5'b11111 || out !== 5'b00010) begin
      mismatched++;
      $display("[TB] FAIL hold_idle: got %h out %b expected %h out 00010", actual(), out, exp);
    end
  endtask

  task automatic test_mid_reset();
    applyStimulus(1'b0, 1'b1, 5'b01101, 5'b11101);
    applyStimulus(1'b1, 1'b1, 5'b11111, 5'b11111);
    void'(sbq.pop_front());
    exp = sbq.pop_front();
    compared++;
    if (actual() !== exp || out_q !== 5'b0 || zero_q !== 1'b1 || out_valid !== 1'b0 || out !== 5'b11111) begin
      mismatched++;
      $display("[TB] FAIL mid_reset: got %h out %b expected %h out 11111", actual(), out, exp);
    end
    applyStimulus(1'b0, 1'b1, 5'b10110, 5'b11011);
    exp = sbq.pop_front();
    compared++;
    if (actual() !== exp || out_q !== 5'b10010) begin
      mismatched++;
      $display("[TB] FAIL after_reset: got %h expected %h", actual(), exp);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = W'($urandom);
      if (n % 7 == 0) b = {W{1'b1}};
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), a, b);
      compared++;
      if (out !== (a & b)) begin
        mismatched++;
        $display("[TB] FAIL random_out: got %b expected %b", out, a & b);
      end
      exp = sbq.pop_front();
      compared++;
      if (actual() !== exp || (zero_q && ones_q)) begin
        mismatched++;
        $display("[TB] FAIL random_reg: got %h expected %h", actual(), exp);
      end
    end
  endtask

`ifdef AND_FIVE_BITS_STATS_EN
  task automatic test_saturation();
    applyStimulus(1'b1, 1'b0, '0, '0);
    void'(sbq.pop_front());
    for (int n = 0; n < 65540; n++) begin
      applyStimulus(1'b0, 1'b1, 5'b00001, 5'b10101);
      exp = sbq.pop_front();
      if (n % 4096 == 0 || n >= 65530) begin
        compared++;
        if (actual() !== exp) begin
          mismatched++;
          $display("[TB] FAIL saturation_step: got %h expected %h", actual(), exp);
        end
      end
    end
    compared++;
    if (match_cnt !== 16'hFFFF) begin
      mismatched++;
      $display("[TB] FAIL saturation_final: got %h expected ffff", match_cnt);
    end
  endtask
`endif

  initial begin
    model = '0;
    model.zero = 1'b1;
    test_reset();
    test_zero();
    test_partial();
    test_back_to_back();
    test_hold();
    test_mid_reset();
    test_random();
`ifdef AND_FIVE_BITS_STATS_EN
    test_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
